// File: rtl/sobel_window_sched_if.sv
// Bundle of the cache read port, window handshake and frame control seen by the
// Sobel window scheduler.
interface sobel_window_sched_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned CNT_W  = 13
) ();
    logic              start;
    logic [CNT_W-1:0]  valid_lines;
    logic [ADDR_W-1:0] rdaddress;
    logic [7:0]        q;
    logic              free_line;
    logic              win_valid;
    logic              win_ready;
    logic [71:0]       win_data;
    logic [9:0]        win_x;
    logic [8:0]        win_y;
    logic              busy;
    logic              done;

    modport master (
        input  start, valid_lines, q, win_ready,
        output rdaddress, free_line, win_valid, win_data, win_x, win_y, busy, done
    );

    modport slave (
        output start, valid_lines, q, win_ready,
        input  rdaddress, free_line, win_valid, win_data, win_x, win_y, busy, done
    );
endinterface

// File: rtl/sobel_window_sched.sv
// Read-side scheduler for the Sobel line cache: walks three ring slots column by column,
// assembles a 3x3 window and releases each finished line back to the cache.
module sobel_window_sched #(
    parameter int unsigned WIDTH  = 800,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned LINES  = 10,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned CNT_W  = 13
) (
    input logic                  clk,
    input logic                  rst,
    sobel_window_sched_if.master bus
);
    typedef enum logic [2:0] {
        StIdle,
        StWaitLines,
        StRead,
        StDrain,
        StEmit,
        StRowEnd
    } state_e;

    localparam int unsigned      HeadW    = $clog2(LINES);
    localparam logic [ADDR_W:0]  RingSize = (ADDR_W + 1)'(LINES * WIDTH);
    localparam logic [ADDR_W:0]  LineStep = (ADDR_W + 1)'(WIDTH);
    localparam logic [CNT_W-1:0] NeedCnt  = CNT_W'(3 * WIDTH);
    localparam logic [9:0]       LastCol  = 10'(WIDTH - 1);
    localparam logic [8:0]       LastRow  = 9'(HEIGHT - 2);
    localparam logic [HeadW-1:0] LastSlot = HeadW'(LINES - 1);

    state_e            state_q, state_d;
    logic [HeadW-1:0]  head_q, head_d;
    logic [ADDR_W-1:0] head_base_q, head_base_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [9:0]        col_q, col_d;
    logic [8:0]        row_q, row_d;
    logic [1:0]        rd_k_q, rd_k_d;
    logic [1:0]        iv_q, iv_d;
    logic [1:0]        cap_q, cap_d;
    logic [7:0]        col0_q, col0_d;
    logic [7:0]        col1_q, col1_d;
    logic [71:0]       win_q, win_d;
    logic              done_q, done_d;
    logic              shift_done;
    logic [23:0]       new_col;
    logic [ADDR_W-1:0] rd_addr;
    logic              emit;

    // Step one ring slot forward without a multiplier.
    function automatic logic [ADDR_W-1:0] next_base(input logic [ADDR_W-1:0] base);
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + LineStep;
        if (sum >= RingSize) begin
            sum = sum - RingSize;
        end
        return sum[ADDR_W-1:0];
    endfunction

    assign rd_addr = rd_base_q + ADDR_W'(col_q);
    assign emit    = (state_q == StEmit);

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        head_base_d = head_base_q;
        rd_base_d   = (state_q == StRead) ? next_base(rd_base_q) : head_base_q;
        addr_hold_d = addr_hold_q;
        col_d       = col_q;
        row_d       = row_q;
        rd_k_d      = rd_k_q;
        iv_d        = {iv_q[0], state_q == StRead};
        cap_d       = cap_q;
        col0_d      = col0_q;
        col1_d      = col1_q;
        win_d       = win_q;
        done_d      = 1'b0;
        shift_done  = 1'b0;
        new_col     = {bus.q, col1_q, col0_q};

        // Data returns in slot order: oldest row first, newest row completes the column.
        if (iv_q[1] && !bus.start) begin
            case (cap_q)
                2'd0: begin
                    col0_d = bus.q;
                    cap_d  = 2'd1;
                end
                2'd1: begin
                    col1_d = bus.q;
                    cap_d  = 2'd2;
                end
                default: begin
                    cap_d      = 2'd0;
                    shift_done = 1'b1;
                    for (int r = 0; r < 3; r++) begin
                        win_d[r*24 +: 8]      = win_q[r*24+8 +: 8];
                        win_d[r*24+8 +: 8]    = win_q[r*24+16 +: 8];
                        win_d[r*24+16 +: 8]   = new_col[r*8 +: 8];
                    end
                end
            endcase
        end

        case (state_q)
            StIdle: ;
            StWaitLines: begin
                if (bus.valid_lines >= NeedCnt) begin
                    state_d = StRead;
                    col_d   = '0;
                end
            end
            StRead: begin
                addr_hold_d = rd_addr;
                if (rd_k_q == 2'd2) begin
                    rd_k_d  = 2'd0;
                    state_d = StDrain;
                end else begin
                    rd_k_d = rd_k_q + 2'd1;
                end
            end
            StDrain: begin
                if (shift_done) begin
                    if (col_q < 10'd2) begin
                        col_d   = col_q + 10'd1;
                        state_d = StRead;
                    end else begin
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                if (bus.win_ready) begin
                    if (col_q == LastCol) begin
                        state_d = StRowEnd;
                    end else begin
                        col_d   = col_q + 10'd1;
                        state_d = StRead;
                    end
                end
            end
            StRowEnd: begin
                head_d      = (head_q == LastSlot) ? '0 : head_q + HeadW'(1);
                head_base_d = next_base(head_base_q);
                if (row_q == LastRow) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    row_d   = row_q + 9'd1;
                    state_d = StWaitLines;
                end
            end
            default: state_d = StIdle;
        endcase

        // Start restarts the frame from any state; pending reads are dropped.
        if (bus.start) begin
            state_d     = StWaitLines;
            head_d      = '0;
            head_base_d = '0;
            row_d       = 9'd1;
            col_d       = '0;
            rd_k_d      = 2'd0;
            iv_d        = 2'b00;
            cap_d       = 2'd0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            head_q      <= '0;
            head_base_q <= '0;
            rd_base_q   <= '0;
            addr_hold_q <= '0;
            col_q       <= '0;
            row_q       <= 9'd1;
            rd_k_q      <= 2'd0;
            iv_q        <= 2'b00;
            cap_q       <= 2'd0;
            col0_q      <= '0;
            col1_q      <= '0;
            win_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            head_base_q <= head_base_d;
            rd_base_q   <= rd_base_d;
            addr_hold_q <= addr_hold_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rd_k_q      <= rd_k_d;
            iv_q        <= iv_d;
            cap_q       <= cap_d;
            col0_q      <= col0_d;
            col1_q      <= col1_d;
            win_q       <= win_d;
            done_q      <= done_d;
        end
    end

    assign bus.rdaddress = (state_q == StRead) ? rd_addr : addr_hold_q;
    assign bus.win_valid = emit && !bus.start;
    assign bus.free_line = (state_q == StRowEnd) && !bus.start;
    assign bus.win_data  = win_q;
    assign bus.win_x     = emit ? col_q - 10'd1 : '0;
    assign bus.win_y     = emit ? row_q : '0;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sobel_window_sched.sv
// Bench for sobel_window_sched: ring-slot cache model, golden 3x3 windows from the image,
// backpressure, starvation, ring wrap and mid-frame abort.
module tb_sobel_window_sched;
    localparam int unsigned W  = 8;
    localparam int unsigned H  = 12;
    localparam int unsigned L  = 5;
    localparam int unsigned AW = 14;
    localparam int unsigned CW = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sobel_window_sched_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    sobel_window_sched #(
        .WIDTH (W),
        .HEIGHT(H),
        .LINES (L),
        .ADDR_W(AW),
        .CNT_W (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] img [H][W];
    int         freed  = 0;
    int         vl_cap = 1 << 20;
    logic [7:0] q_p1   = '0;

    // Resident lines are freed..freed+L-1; line n lives in slot n mod L.
    function automatic logic [7:0] pix_at(input logic [AW-1:0] a, input int fr);
        int s, x, line;
        s    = int'(a) / W;
        x    = int'(a) % W;
        line = fr + ((s - (fr % L) + L) % L);
        if (line < H && s < L) return img[line][x];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        q_p1  <= pix_at(bus.rdaddress, freed);
        bus.q <= q_p1;
        if (bus.start) freed <= 0;
        else if (bus.free_line) freed <= freed + 1;
    end

    always_comb begin
        int res;
        int vl;
        res = H - freed;
        if (res > L) res = L;
        vl = res * W;
        if (vl > vl_cap) vl = vl_cap;
        bus.valid_lines = CW'(vl);
    end

    logic          rec_en    = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] addr_log [$];

    always @(negedge clk) begin
        if (rec_en && bus.rdaddress !== last_addr) begin
            addr_log.push_back(bus.rdaddress);
            last_addr <= bus.rdaddress;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic fill_image(input bit inc);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = inc ? 8'(y * W + x) : 8'($urandom);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Consume windows until done, checking each against the image neighbourhood.
    task automatic run_frame(input int bp, input int stop_after);
        logic [71:0] ed [$];
        int          ex [$];
        int          ey [$];
        int          widx = 0;
        int          frees = 0;
        bit          prev_free = 1'b0;
        bit          prev_hs = 1'b0;
        bit          finished = 1'b0;
        bit          force_ready;
        for (int y = 1; y <= H - 2; y++) begin
            for (int x = 1; x <= W - 2; x++) begin
                logic [71:0] d;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        d[(r*3+c)*8 +: 8] = img[y-1+r][x-1+c];
                ed.push_back(d);
                ex.push_back(x);
                ey.push_back(y);
            end
        end
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            @(negedge clk);
            force_ready = 1'b0;
            if (prev_hs) check("valid_drop", bus.win_valid, 0);
            prev_hs = 1'b0;
            if (bus.free_line) begin
                frees++;
                check("free_no_valid", bus.win_valid, 0);
            end
            if (bus.done) begin
                check("done_after_free", prev_free, 1);
                check("free_count", frees, H - 2);
                check("busy_clear", bus.busy, 0);
                finished = 1'b1;
            end
            prev_free = bus.free_line;
            if (bus.win_valid) begin
                if (stop_after > 0 && widx == stop_after) begin
                    bus.win_ready = 1'b0;
                    return;
                end
                if (widx == 0) check("busy_set", bus.busy, 1);
                if (bp > 0 && widx == 0) begin
                    for (int i = 0; i < bp; i++) begin
                        bus.win_ready = 1'b0;
                        check("bp_valid", bus.win_valid, 1);
                        check("bp_data", bus.win_data, ed[0]);
                        check("bp_x", bus.win_x, ex[0]);
                        check("bp_y", bus.win_y, ey[0]);
                        @(negedge clk);
                    end
                    check("bp_valid", bus.win_valid, 1);
                    bp = 0;
                    force_ready = 1'b1;
                end
                bus.win_ready = force_ready ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                if (bus.win_ready) begin
                    if (widx < ed.size()) begin
                        check("win_x", bus.win_x, ex[widx]);
                        check("win_y", bus.win_y, ey[widx]);
                        check("win_data", bus.win_data, ed[widx]);
                    end else begin
                        check("extra_window", widx, ed.size());
                    end
                    widx++;
                    prev_hs = 1'b1;
                end
            end else begin
                bus.win_ready = 1'($urandom_range(0, 1));
            end
        end
        check("frame_done", finished, 1);
        check("win_count", widx, ed.size());
    endtask

    initial begin
        logic [AW-1:0] exp_addr [$];
        logic [AW-1:0] prev;
        logic [AW-1:0] held;
        int            a;

        bus.start     = 1'b0;
        bus.win_ready = 1'b0;

        // Reset dominates start and win_ready.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start     = 1'($urandom);
            bus.win_ready = 1'($urandom);
            #1;
            check("reset_outs", {bus.rdaddress, bus.free_line, bus.win_valid, bus.win_data,
                                 bus.win_x, bus.win_y, bus.busy, bus.done}, '0);
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.win_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_valid", bus.win_valid, 0);
        check("idle_addr", bus.rdaddress, 0);

        // Frame 1: incrementing pixels, backpressure on the first window, address trace.
        fill_image(1'b1);
        rec_en = 1'b1;
        pulse_start();
        run_frame(7, 0);
        rec_en = 1'b0;
        prev = '0;
        for (int y = 1; y <= H - 2; y++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < 3; k++) begin
                    a = ((y - 1 + k) % L) * W + c;
                    if (AW'(a) != prev) exp_addr.push_back(AW'(a));
                    prev = AW'(a);
                end
        check("addr_count", addr_log.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
            check("addr_seq", addr_log[i], exp_addr[i]);
            if (addr_log[i] !== exp_addr[i]) break;
        end

        // Frame 2: starve one pixel short of three lines, then release.
        held = AW'(((H - 1) % L) * W + (W - 1));
        fill_image(1'b0);
        vl_cap = 3 * W - 1;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("starve_addr", bus.rdaddress, held);
            check("starve_valid", bus.win_valid, 0);
            check("starve_busy", bus.busy, 1);
        end
        vl_cap = 3 * W;
        @(negedge clk);
        check("first_read", bus.rdaddress, 0);
        vl_cap = 1 << 20;
        run_frame(0, 0);

        // Frame 3: abort while a row-2 window is offered, then a full clean frame.
        fill_image(1'b0);
        pulse_start();
        run_frame(0, W - 2 + 2);
        bus.start = 1'b1;
        #1;
        check("abort_valid", bus.win_valid, 0);
        check("abort_free", bus.free_line, 0);
        check("abort_done", bus.done, 0);
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_busy", bus.busy, 1);
        check("abort_valid_next", bus.win_valid, 0);
        run_frame(0, 0);

        // Frame 4: fresh random image with random ready.
        fill_image(1'b0);
        pulse_start();
        run_frame(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sobel_window_sched.md
Name: sobel_window_sched

Overview:
- Read-side controller for the Sobel line cache. Tracks which ring slots hold the three rows around the current output row, and waits until enough pixels are resident.
- Issues column-wise cache reads, assembles a 3x3 pixel window and hands it to the Sobel core with a valid/ready handshake.
- Pulses free_line after each finished row so the cache can refill.
- Sits between the cache's read port (rdaddress/q/valid_lines/free_line) and the gradient datapath.

Parameters:
- WIDTH, 800: pixels per image line.
- HEIGHT, 480: lines per frame.
- LINES, 10: line slots in the cache ring. LINES*WIDTH must fit in ADDR_W.
- ADDR_W, 14: cache read address width.
- CNT_W, 13: width of the valid_lines input.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start. Same cycle as the cache's start.
- valid_lines  in  CNT_W  resident, unfreed pixel count reported by the cache.
- rdaddress  out  ADDR_W  cache read address.
- q  in  8  cache read data. Two-cycle latency from rdaddress.
- free_line  out  1  one-cycle pulse; releases the oldest line (WIDTH pixels).
- win_valid  out  1  window available.
- win_ready  in  1  consumer accepts the window.
- win_data  out  72  3x3 window, row-major. [7:0] is (y-1,x-1); [71:64] is (y+1,x+1).
- win_x  out  10  centre column, 1..WIDTH-2.
- win_y  out  9  centre row, 1..HEIGHT-2.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final free_line.

Behaviour:
- Reset (rst=0): state IDLE; all outputs 0; head slot 0; column counter col=0; row counter row=1; window and column registers 0.
- States: IDLE, WAIT_LINES, READ, DRAIN, EMIT, ROW_END.
- IDLE: on start, go to WAIT_LINES. Set head=0, row=1, col=0, busy=1.
- WAIT_LINES: stay while valid_lines < 3*WIDTH (unsigned compare). Otherwise go to READ with col=0.
- READ: exactly 3 cycles. rdaddress = slot_base(k) + col for k = 0, 1, 2, where slot_base(k) = ((head+k) mod LINES)*WIDTH.
  - Computed by add/compare-subtract. No multiplier.
  - The wrap condition is base+WIDTH >= LINES*WIDTH, in which case subtract LINES*WIDTH.
- DRAIN: q for the address issued in cycle t is captured at t+2. This is tracked by a 2-deep issue-valid shift register.
- After the third capture (5 cycles after READ entry), the window shifts one column left; the new column enters at the right.
- Column dispatch after the shift:
  - col<2: col+1, back to READ (priming).
  - col>=2: go to EMIT.
- EMIT: win_valid=1 with win_x=col-1, win_y=row.
  - win_data, win_x and win_y stay stable while win_valid=1 and win_ready=0.
  - On win_valid&&win_ready, drop win_valid the next cycle.
  - Then: col==WIDTH-1 goes to ROW_END; otherwise col+1 and READ.
- Output count: WIDTH-2 windows per row, (WIDTH-2)*(HEIGHT-2) per frame.
- ROW_END: free_line=1 for exactly one cycle; head advances by one slot, mod LINES.
  - If row==HEIGHT-2: go to IDLE, done=1 for one cycle, busy=0.
  - Otherwise: row+1, go to WAIT_LINES. WAIT_LINES first samples valid_lines the cycle after the pulse, when the cache count has already dropped by WIDTH.
- Frame totals: exactly HEIGHT-2 free_line pulses. The last two lines are not freed; the next start clears the cache.
- start while busy: synchronous abort.
  - Same cycle: win_valid, free_line and done are forced to 0.
  - Next cycle: WAIT_LINES with head=0, row=1, col=0.
  - In-flight reads are discarded by clearing the issue-valid pipe.
- start in IDLE while rst=0: ignored. Reset dominates.
- win_ready ignored when win_valid=0. free_line never asserts in the same cycle as win_valid.
- rdaddress holds its last value outside READ.

Test Plan:
- Reset: hold rst=0, toggle start and win_ready -> all outputs 0; state IDLE after release.
- Small frame (WIDTH=8, HEIGHT=4, LINES=5), behavioural cache model with an incrementing pixel pattern, win_ready=1:
  - 12 windows, each matching the golden 3x3 neighbourhood.
  - win_x runs 1..6 for win_y=1, then for win_y=2.
  - 2 free_line pulses; done one cycle after the second.
- Backpressure: win_ready=0 for 7 cycles on the first window -> win_valid held; win_data/win_x/win_y unchanged; no READ issued; accepted on the first ready cycle.
- Starvation: valid_lines held at 3*WIDTH-1 -> no rdaddress change and no windows. Raise to 3*WIDTH -> first READ the following cycle.
- Ring wrap: WIDTH=8, HEIGHT=12, LINES=5 -> after 3 rows, head slots (3,4,0) give addresses 24..39, then 0..7. Windows remain correct through the wrap.
- Abort: start pulsed mid-row with win_valid=1 -> win_valid=0 that cycle. No free_line or done. The frame restarts at win_y=1, win_x=1 with correct data.
